// File: rtl/avalon_burst_writer.sv
// Stream-to-Avalon-MM burst writer: buffers words in a FIFO and issues fixed-length write bursts.
// Optional AVALON_BURST_WRITER_FLUSH_EN adds a flush input that drains a partial FIFO as a short burst.
module avalon_burst_writer #(
    parameter int unsigned BURSTCOUNT_W = 4,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned FIFO_DEPTH_W = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned REGION_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [31:0]             address,
    output logic                    write,
    output logic [31:0]             writedata,
    output logic [3:0]              byteenable,
    output logic [BURSTCOUNT_W-1:0] burstcount,
    input  logic                    waitrequest,
`ifdef AVALON_BURST_WRITER_FLUSH_EN
    input  logic                    flush,
`endif
    output logic                    busy,
    output logic [15:0]             bursts_done
);

    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_W;
    localparam int unsigned CW    = FIFO_DEPTH_W + 1;

    localparam logic [CW-1:0]           FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]           LEN_CNT   = CW'(BURST_LEN);
    localparam logic [BURSTCOUNT_W-1:0] LEN_BC    = BURSTCOUNT_W'(BURST_LEN);
    localparam logic [31:0]             PTR_STEP  = 32'(BURST_LEN);
    localparam logic [31:0]             PTR_LIMIT = 32'(REGION_WORDS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             mem_q [DEPTH];
    logic [FIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [BURSTCOUNT_W-1:0] len_q, len_d;
    logic [BURSTCOUNT_W-1:0] beats_q, beats_d;
    logic [31:0]             word_ptr_q, word_ptr_d;
    logic [31:0]             word_ptr_sum;
    logic [15:0]             done_q, done_d;
    logic                    flush_pend_q;
    logic                    push;
    logic                    pop;

    assign s_ready      = (count_q != FULL_CNT) && !flush_pend_q;
    assign push         = s_valid && s_ready;
    assign pop          = (state_q == BURST) && !waitrequest;

    assign write        = (state_q == BURST);
    assign busy         = (state_q == BURST);
    assign byteenable   = (state_q == BURST) ? '1 : '0;
    assign writedata    = mem_q[rd_ptr_q];
    assign address      = BASE_ADDR + (word_ptr_q << 2);
    assign burstcount   = len_q;
    assign bursts_done  = done_q;
    assign word_ptr_sum = word_ptr_q + PTR_STEP;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        len_d      = len_q;
        beats_d    = beats_q;
        word_ptr_d = word_ptr_q;
        done_d     = done_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (count_q >= LEN_CNT) begin
                    state_d = BURST;
                    len_d   = LEN_BC;
                    beats_d = LEN_BC;
                end else if (flush_pend_q && (count_q != '0)) begin
                    state_d = BURST;
                    len_d   = BURSTCOUNT_W'(count_q);
                    beats_d = BURSTCOUNT_W'(count_q);
                end
            end
            BURST: begin
                if (pop) begin
                    beats_d = beats_q - BURSTCOUNT_W'(1);
                    if (beats_q == BURSTCOUNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = done_q + 16'd1;
                        // word_ptr only ever holds multiples of BURST_LEN, so a plain
                        // step also covers rounding up after a short flushed burst.
                        word_ptr_d = (word_ptr_sum >= PTR_LIMIT) ? '0 : word_ptr_sum;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            len_q      <= '0;
            beats_q    <= '0;
            word_ptr_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            len_q      <= len_d;
            beats_q    <= beats_d;
            word_ptr_q <= word_ptr_d;
            done_q     <= done_d;
        end
    end

`ifdef AVALON_BURST_WRITER_FLUSH_EN
    logic flush_pend_d;

    // A new flush pulse wins over the empty-FIFO clear.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush) begin
            flush_pend_d = 1'b1;
        end else if ((state_q == IDLE) && (count_q == '0)) begin
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign flush_pend_q = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_burst_writer.sv
// Self-checking bench for avalon_burst_writer: queue-based reference model plus directed scenarios.
module tb_avalon_burst_writer;

    localparam int BL     = 8;
    localparam int DEPTH  = 16;
    localparam int REGION = 256;

    logic        clk;
    logic        reset_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [3:0]  burstcount;
    logic        waitrequest;
    logic        flush;
    logic        busy;
    logic [15:0] bursts_done;

    avalon_burst_writer #(
        .BURSTCOUNT_W (4),
        .BURST_LEN    (BL),
        .FIFO_DEPTH_W (4),
        .BASE_ADDR    (32'h0),
        .REGION_WORDS (REGION)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .burstcount  (burstcount),
        .waitrequest (waitrequest),
`ifdef AVALON_BURST_WRITER_FLUSH_EN
        .flush       (flush),
`endif
        .busy        (busy),
        .bursts_done (bursts_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO contents, burst progress and burst index
    logic [31:0] mq[$];
    bit          m_burst = 0;
    int          m_beats = 0;
    int          m_len   = 0;
    int          m_idx   = 0;
    logic [15:0] m_done  = '0;
    bit          m_flush = 0;
    bit          started = 0;
    int          cyc     = 0;

    always @(posedge clk) begin
        int  sz;
        bit  was_burst;
        bit  acc;
        cyc++;
        started = 1;
        if (!reset_n) begin
            mq.delete();
            m_burst = 0;
            m_beats = 0;
            m_idx   = 0;
            m_done  = '0;
            m_flush = 0;
        end else begin
            sz        = mq.size();
            was_burst = m_burst;
            acc       = s_valid && (sz < DEPTH) && !m_flush;
            if (was_burst) begin
                if (!waitrequest) begin
                    void'(mq.pop_front());
                    m_beats--;
                    if (m_beats == 0) begin
                        m_burst = 0;
                        m_idx++;
                        m_done++;
                    end
                end
            end else if (sz >= BL) begin
                m_burst = 1; m_len = BL; m_beats = BL;
            end else if (m_flush && sz > 0) begin
                m_burst = 1; m_len = sz; m_beats = sz;
            end
            if (acc) mq.push_back(s_data);
            if (flush) m_flush = 1;
            else if (!was_burst && sz == 0) m_flush = 0;
        end
    end

    // DUT observations used by directed checks
    logic [31:0] beat_log[$];
    int          beat_cyc[$];
    logic [31:0] start_addr[$];
    logic [31:0] start_bc[$];
    bit          prev_write = 0;

    always @(negedge clk) begin
        if (started) begin
            check("write", write, m_burst);
            check("busy", busy, m_burst);
            check("s_ready", s_ready, (mq.size() < DEPTH) && !m_flush);
            check("bursts_done", bursts_done, m_done);
            if (m_burst && mq.size() > 0) begin
                check("writedata", writedata, mq[0]);
                check("address", address, 32'((m_idx * BL) % REGION) * 4);
                check("burstcount", burstcount, m_len);
                check("byteenable", byteenable, 4'hF);
            end
            if (reset_n && write && !waitrequest) begin
                beat_log.push_back(writedata);
                beat_cyc.push_back(cyc + 1);
            end
            if (write && !prev_write) begin
                start_addr.push_back(address);
                start_bc.push_back(32'(burstcount));
            end
            prev_write = write;
        end
    end

    task automatic clear_logs();
        beat_log.delete();
        beat_cyc.delete();
        start_addr.delete();
        start_bc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; s_valid = 1'b0; waitrequest = 1'b0; flush = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic push_word(input logic [31:0] d);
        bit r;
        bit ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: word %h not accepted within bound", d);
        end
    endtask

    task automatic wait_done(input logic [15:0] n, input int lim);
        for (int i = 0; i < lim && bursts_done != n; i++) @(negedge clk);
        check("wait_bursts_done", bursts_done, n);
    endtask

    initial begin
        int stalls;
        int p17;
        reset_n = 1'b0; s_valid = 1'b0; waitrequest = 1'b0; flush = 1'b0; s_data = '0;

        // Reset state and single full burst
        do_reset();
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        check("rst_done", bursts_done, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        s_valid = 1'b0;
        wait_done(16'd1, 100);
        check("t1_beats", beat_log.size(), 8);
        if (beat_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_data", beat_log[i], 32'h100 + 32'(i));
                check("t1_consec", beat_cyc[i] - beat_cyc[0], i);
            end
        end
        if (start_addr.size() > 0) begin
            check("t1_addr", start_addr[0], 32'h0);
            check("t1_bc", start_bc[0], 8);
        end

        // Stall three cycles while beat 2 is presented
        do_reset();
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        s_valid = 1'b0;
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            if (write && beat_log.size() == 2 && stalls < 3) begin
                waitrequest = 1'b1;
                stalls++;
            end else begin
                waitrequest = 1'b0;
            end
            @(negedge clk);
            if (waitrequest) begin
                check("t2_hold_data", writedata, 32'h102);
                check("t2_hold_addr", address, 32'h0);
                check("t2_hold_write", write, 1);
            end
            @(posedge clk); #1;
            if (bursts_done == 16'd1) break;
        end
        waitrequest = 1'b0;
        check("t2_done", bursts_done, 1);
        check("t2_beats", beat_log.size(), 8);
        if (beat_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t2_data", beat_log[i], 32'h100 + 32'(i));
            check("t2_span", beat_cyc[7] - beat_cyc[0], 10);
        end

        // 33 bursts streamed back to back, address wraps after 32
        do_reset();
        for (int w = 0; w < 33 * BL; w++) push_word(32'h1000 + 32'(w));
        s_valid = 1'b0;
        wait_done(16'd33, 400);
        check("t3_starts", start_addr.size(), 33);
        if (start_addr.size() == 33) begin
            for (int k = 0; k < 33; k++) check("t3_addr", start_addr[k], 32'((k % 32) * 32));
            check("t3_addr_last_in_window", start_addr[31], 32'h3E0);
            check("t3_addr_wrap", start_addr[32], 32'h0);
        end

        // FIFO full under permanent waitrequest
        do_reset();
        waitrequest = 1'b1;
        for (int i = 0; i < 16; i++) push_word(32'h200 + 32'(i));
        s_data = 32'h210;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_full_ready", s_ready, 0);
            check("t4_write_stalled", write, 1);
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        push_word(32'h210);
        p17 = cyc;
        s_valid = 1'b0;
        if (beat_cyc.size() > 0) check("t4_17th_edge", p17 - beat_cyc[0], 1);
        else check("t4_first_beat", beat_cyc.size(), 1);
        wait_done(16'd2, 100);
        check("t4_beats", beat_log.size(), 16);
        if (beat_log.size() == 16) begin
            for (int i = 0; i < 16; i++) check("t4_data", beat_log[i], 32'h200 + 32'(i));
        end

        // Reset after beat 4 aborts the burst
        do_reset();
        for (int i = 0; i < 8; i++) push_word(32'h300 + 32'(i));
        s_valid = 1'b0;
        for (int i = 0; i < 50 && beat_log.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_write", write, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", s_ready, 1);
        check("t5_done", bursts_done, 0);
        check("t5_beats", beat_log.size(), 4);
        @(posedge clk); #1;
        clear_logs();
        for (int i = 0; i < 7; i++) push_word(32'h310 + 32'(i));
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_burst_7", write, 0);
        end
        @(posedge clk); #1;
        push_word(32'h317);
        s_valid = 1'b0;
        wait_done(16'd1, 100);
        if (start_addr.size() > 0) check("t5_addr", start_addr[0], 32'h0);
        check("t5_beats2", beat_log.size(), 8);
        if (beat_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t5_data", beat_log[i], 32'h310 + 32'(i));
        end

`ifdef AVALON_BURST_WRITER_FLUSH_EN
        // Flush a 3-word partial burst, next full burst lands at 0x20
        do_reset();
        for (int i = 0; i < 3; i++) push_word(32'h400 + 32'(i));
        s_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done(16'd1, 50);
        if (start_addr.size() > 0) begin
            check("t6_addr", start_addr[0], 32'h0);
            check("t6_bc", start_bc[0], 3);
        end
        check("t6_beats", beat_log.size(), 3);
        for (int i = 0; i < 8; i++) push_word(32'h410 + 32'(i));
        s_valid = 1'b0;
        wait_done(16'd2, 100);
        if (start_addr.size() > 1) check("t6_next_addr", start_addr[1], 32'h20);
        else check("t6_starts", start_addr.size(), 2);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/avalon_burst_writer.md
AVALON_BURST_WRITER -- requirements
Module: avalon_burst_writer

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Parameter BURSTCOUNT_W, default 4, SHALL be the burstcount width; max burst is 2**(BURSTCOUNT_W-1).
REQ-003 Parameter BURST_LEN, default 8, SHALL be the words per full burst; constraint 1 <= BURST_LEN <= 2**(BURSTCOUNT_W-1).
REQ-004 Parameter FIFO_DEPTH_W, default 4, SHALL set FIFO depth to 2**FIFO_DEPTH_W words; depth >= BURST_LEN.
REQ-005 Parameters BASE_ADDR, default 0, and REGION_WORDS, default 256, SHALL set the target window; REGION_WORDS is a multiple of BURST_LEN.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  sync active-low reset
- s_data  in  32  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  block accepts word
- address  out  32  Avalon byte address
- write  out  1  Avalon write request
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte lanes
- burstcount  out  BURSTCOUNT_W  Avalon burst length
- waitrequest  in  1  Avalon agent stall
- busy  out  1  burst in progress
- bursts_done  out  16  completed-burst counter

Function
REQ-007 A push SHALL occur on a clk edge where s_valid && s_ready; s_ready SHALL equal FIFO-not-full; the FIFO is first-word-first-out.
REQ-008 FSM states SHALL be IDLE and BURST; IDLE -> BURST on an edge where FIFO count >= BURST_LEN, latching len = BURST_LEN.
REQ-009 In BURST: write=1, byteenable=4'hF, burstcount=len, address=BASE_ADDR+4*word_ptr, all held constant for the whole burst; writedata = FIFO head.
REQ-010 A beat SHALL be accepted on an edge with write && !waitrequest; that beat pops the FIFO and decrements the beat counter.
REQ-011 On the last accepted beat, the FSM SHALL return to IDLE (write=0 for at least one cycle), word_ptr advances by BURST_LEN modulo REGION_WORDS, and bursts_done increments (wraps at 16 bits).
REQ-012 busy SHALL be 1 exactly while in BURST.
REQ-013 Simultaneous push and pop SHALL leave the count unchanged; a push into a full FIFO SHALL NOT occur (s_ready=0).
REQ-014 Outputs write, writedata, address, and burstcount SHALL be stable while waitrequest=1.
REQ-015 In IDLE, write SHALL be 0 and writedata/address/burstcount are don't-care.

Reset
REQ-016 On an edge with reset_n=0: state=IDLE, write=0, FIFO emptied, word_ptr=0, bursts_done=0, busy=0, and s_ready=1 from the following cycle.
REQ-017 A reset asserted mid-burst SHALL abort the burst at that edge, with no further beats issued.

Configuration
REQ-018 With macro AVALON_BURST_WRITER_FLUSH_EN defined, the block SHALL add input port flush (1 bit); a flush pulse sets flush_pending.
REQ-019 While flush_pending=1, s_ready SHALL be 0.
REQ-020 In IDLE with flush_pending=1 and 0 < count < BURST_LEN, the block SHALL issue a burst with len=count.
REQ-021 After a flushed burst, word_ptr SHALL advance to the next multiple of BURST_LEN (modulo REGION_WORDS).
REQ-022 flush_pending SHALL clear in IDLE when count=0.
REQ-023 Without the macro, the flush port SHALL be absent and only full bursts SHALL occur.

Verification
REQ-024 Reset, then push 8 words 0x100..0x107 with waitrequest=0 -> one burst: address=0x0, burstcount=8, data 0x100..0x107 on 8 consecutive cycles; bursts_done=1.
REQ-025 Same stimulus with waitrequest high for 3 cycles on beat 2 -> beat 2 data 0x102 and address 0x0 held stable; total 8 pops; no beat lost or duplicated.
REQ-026 Stream 33 bursts continuously with s_valid=1 -> addresses cycle 0x000, 0x020, ..., 0x3E0, then wrap to 0x000; bursts_done=33.
REQ-027 Hold waitrequest=1 and push 17 words -> s_ready=0 after 16 words; the 17th word is accepted only after the first beat is accepted.
REQ-028 Assert reset_n=0 after beat 4 of a burst -> write=0 on the next cycle, FIFO empty, word_ptr=0; a subsequent 8-word push bursts at address 0x0.
REQ-029 With AVALON_BURST_WRITER_FLUSH_EN, push 3 words then pulse flush -> burst with burstcount=3 at 0x0; the next full burst goes to address 0x20.
